cd_hms_fmt: RTL and testbench

Downstream consumer of the 17-bit countdown seconds value. Converts the binary seconds count into six BCD display digits (HH:MM:SS) using a multi-cycle iterative-subtraction state machine. Detects expiry, a nonzero-to-zero transition while the countdown is running, and drives a timed alarm output to the buzzer/LED stage. Feeds the seven-segment scan driver.

---
 rtl/cd_hms_fmt_if.sv | 28 ++
 rtl/cd_hms_fmt.sv | 157 +++++++++++++++
 tb/tb_cd_hms_fmt.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cd_hms_fmt_if.sv
// Display-side bundle for the countdown HH:MM:SS formatter.
// Carries the seconds/run/ack inputs and the BCD digit, status and alarm outputs.
interface cd_hms_fmt_if;
    logic [16:0] seconds;
    logic        running;
    logic        ack;
    logic [3:0]  h_tens;
    logic [3:0]  h_ones;
    logic [3:0]  m_tens;
    logic [3:0]  m_ones;
    logic [3:0]  s_tens;
    logic [3:0]  s_ones;
    logic        update;
    logic        busy;
    logic        alarm;

    modport master (
        output seconds, running, ack,
        input  h_tens, h_ones, m_tens, m_ones, s_tens, s_ones,
        input  update, busy, alarm
    );

    modport slave (
        input  seconds, running, ack,
        output h_tens, h_ones, m_tens, m_ones, s_tens, s_ones,
        output update, busy, alarm
    );
endinterface

// File: rtl/cd_hms_fmt.sv
// Countdown seconds to HH:MM:SS BCD converter with expiry alarm.
// Iterative subtraction keeps the datapath to one 17-bit subtractor.
module cd_hms_fmt #(
    parameter logic [31:0] ALARM_CYCLES = 32'd500_000_000
) (
    input  logic         clk,
    input  logic         rst,
    cd_hms_fmt_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        HOURS,
        MINS,
        SPLIT,
        DONE
    } state_t;

    state_t      state;
    logic [16:0] work;
    logic [16:0] shadow;
    logic [5:0]  hrs;
    logic [5:0]  mins;
    logic [3:0]  ht;
    logic [3:0]  ho;
    logic [3:0]  mt;
    logic [3:0]  mo;
    logic [3:0]  st;
    logic [3:0]  so;
    logic        prev_zero;
    logic [31:0] cnt;
    logic        expire;

    // Returns {tens, ones} for a value 0..59 using a compare chain.
    function automatic logic [7:0] split(input logic [5:0] v);
        logic [3:0] t;
        logic [5:0] b;
        if (v >= 6'd50) begin
            t = 4'd5;
            b = 6'd50;
        end else if (v >= 6'd40) begin
            t = 4'd4;
            b = 6'd40;
        end else if (v >= 6'd30) begin
            t = 4'd3;
            b = 6'd30;
        end else if (v >= 6'd20) begin
            t = 4'd2;
            b = 6'd20;
        end else if (v >= 6'd10) begin
            t = 4'd1;
            b = 6'd10;
        end else begin
            t = 4'd0;
            b = 6'd0;
        end
        return {t, 4'(v - b)};
    endfunction

    assign expire = (shadow == 17'd0) && !prev_zero && bus.running;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            work       <= '0;
            shadow     <= '0;
            hrs        <= '0;
            mins       <= '0;
            ht         <= '0;
            ho         <= '0;
            mt         <= '0;
            mo         <= '0;
            st         <= '0;
            so         <= '0;
            prev_zero  <= 1'b1;
            cnt        <= '0;
            bus.h_tens <= '0;
            bus.h_ones <= '0;
            bus.m_tens <= '0;
            bus.m_ones <= '0;
            bus.s_tens <= '0;
            bus.s_ones <= '0;
            bus.update <= 1'b0;
            bus.busy   <= 1'b0;
            bus.alarm  <= 1'b0;
        end else begin
            bus.update <= 1'b0;

            // Hold/timeout/ack; an expiry in DONE below overrides this.
            if (bus.ack) begin
                bus.alarm <= 1'b0;
                cnt       <= '0;
            end else if (bus.alarm) begin
                cnt <= cnt - 32'd1;
                if (cnt <= 32'd1) begin
                    bus.alarm <= 1'b0;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.seconds != shadow) begin
                        work     <= bus.seconds;
                        shadow   <= bus.seconds;
                        hrs      <= '0;
                        mins     <= '0;
                        bus.busy <= 1'b1;
                        state    <= HOURS;
                    end
                end
                HOURS: begin
                    if (work >= 17'd3600) begin
                        work <= work - 17'd3600;
                        hrs  <= hrs + 6'd1;
                    end else begin
                        state <= MINS;
                    end
                end
                MINS: begin
                    if (work >= 17'd60) begin
                        work <= work - 17'd60;
                        mins <= mins + 6'd1;
                    end else begin
                        state <= SPLIT;
                    end
                end
                SPLIT: begin
                    {ht, ho} <= split(hrs);
                    {mt, mo} <= split(mins);
                    {st, so} <= split(work[5:0]);
                    state    <= DONE;
                end
                DONE: begin
                    bus.h_tens <= ht;
                    bus.h_ones <= ho;
                    bus.m_tens <= mt;
                    bus.m_ones <= mo;
                    bus.s_tens <= st;
                    bus.s_ones <= so;
                    bus.update <= 1'b1;
                    bus.busy   <= 1'b0;
                    prev_zero  <= (shadow == 17'd0);
                    if (expire) begin
                        bus.alarm <= 1'b1;
                        cnt       <= ALARM_CYCLES;
                    end
                    state <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cd_hms_fmt.sv
// Scoreboard bench for cd_hms_fmt: directed conversions, alarm and reset cases.
// Expected digits are BCD-packed as 24'hHHMMSS.
module tb_cd_hms_fmt;

    typedef struct {
        logic [23:0] dig;
        int          cyc;
        int          bsy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        sbq[$];
    exp_t        e;
    logic [23:0] dig;
    logic [23:0] last_dig = '0;
    bit          unstable = 1'b0;
    int          bcnt = 0;

    always #5 clk = ~clk;

    cd_hms_fmt_if bus();

    cd_hms_fmt #(.ALARM_CYCLES(32'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign dig = {bus.h_tens, bus.h_ones, bus.m_tens,
                  bus.m_ones, bus.s_tens, bus.s_ones};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every update pulse.
    always @(negedge clk) begin
        if (!rst) begin
            last_dig = '0;
            unstable = 1'b0;
            bcnt     = 0;
        end else if (bus.update) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: got %0h want none", dig);
            end else begin
                e = sbq.pop_front();
                check("digits", dig, e.dig);
                check("latency", cyc, e.cyc);
                check("busy_cycles", bcnt, e.bsy);
                check("stable_before_update", {31'd0, unstable}, 0);
            end
            last_dig = dig;
            unstable = 1'b0;
            bcnt     = 0;
        end else begin
            if (dig != last_dig) unstable = 1'b1;
            if (bus.busy) bcnt++;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic conv(logic [16:0] s, logic [23:0] d, int h, int m);
        @(negedge clk);
        bus.seconds = s;
        sbq.push_back('{dig: d, cyc: cyc + 1 + h + m + 4, bsy: h + m + 4});
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_idle_timeout: got busy want idle");
        end
        tick(2);
    endtask

    task automatic wait_update();
        int n = 0;
        while (!bus.update && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL wait_update_timeout: got none want update");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        int  n;
        logic hi;

        rst         = 1'b0;
        bus.seconds = '0;
        bus.running = 1'b0;
        bus.ack     = 1'b0;
        tick(3);
        check("rst_digits", dig, 0);
        check("rst_update", bus.update, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_alarm", bus.alarm, 0);
        @(negedge clk);
        rst = 1'b1;
        tick(6);
        check("zero_idle_busy", bus.busy, 0);
        check("zero_idle_digits", dig, 0);
        check("zero_idle_alarm", bus.alarm, 0);

        conv(17'd3725, 24'h010205, 1, 2);
        wait_idle();
        conv(17'd131071, 24'h362431, 36, 24);
        wait_idle();

        // Input change two cycles into a conversion is queued, not aborted.
        @(negedge clk);
        bus.seconds = 17'd59;
        c = cyc;
        sbq.push_back('{dig: 24'h000059, cyc: c + 5, bsy: 4});
        tick(2);
        bus.seconds = 17'd3600;
        sbq.push_back('{dig: 24'h010000, cyc: c + 11, bsy: 5});
        wait_idle();

        // Expiry while running: alarm for exactly 8 cycles.
        bus.running = 1'b1;
        conv(17'd1, 24'h000001, 0, 0);
        wait_idle();
        conv(17'd0, 24'h000000, 0, 0);
        wait_update();
        check("alarm_rise", bus.alarm, 1);
        n = 0;
        while (bus.alarm && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("alarm_len", n, 8);
        wait_idle();

        // Reaching zero while stopped.
        conv(17'd1, 24'h000001, 0, 0);
        wait_idle();
        bus.running = 1'b0;
        conv(17'd0, 24'h000000, 0, 0);
        wait_update();
        hi = bus.alarm;
        repeat (10) begin
            @(negedge clk);
            hi = hi | bus.alarm;
        end
        check("no_alarm_stopped", hi, 0);
        bus.running = 1'b1;
        wait_idle();

        // Ack on alarm cycle 3.
        conv(17'd1, 24'h000001, 0, 0);
        wait_idle();
        conv(17'd0, 24'h000000, 0, 0);
        wait_update();
        check("ack_alarm_rise", bus.alarm, 1);
        tick(2);
        check("alarm_cycle3", bus.alarm, 1);
        bus.ack = 1'b1;
        tick(1);
        check("ack_clear", bus.alarm, 0);
        bus.ack = 1'b0;
        wait_idle();

        // Expiry beats a simultaneous ack.
        conv(17'd1, 24'h000001, 0, 0);
        wait_idle();
        bus.ack = 1'b1;
        conv(17'd0, 24'h000000, 0, 0);
        wait_update();
        check("expiry_over_ack", bus.alarm, 1);
        tick(1);
        check("ack_after_expiry", bus.alarm, 0);
        bus.ack = 1'b0;
        wait_idle();

        // New nonzero value does not clear a pending alarm.
        conv(17'd1, 24'h000001, 0, 0);
        wait_idle();
        conv(17'd0, 24'h000000, 0, 0);
        wait_update();
        conv(17'd5, 24'h000005, 0, 0);
        wait_update();
        check("alarm_hold_newval", bus.alarm, 1);
        wait_idle();
        tick(5);
        check("alarm_timeout", bus.alarm, 0);

        // Reset in the middle of a conversion.
        conv(17'd7322, 24'h020202, 2, 2);
        wait_idle();
        @(negedge clk);
        bus.seconds = 17'd3725;
        tick(3);
        check("busy_before_rst", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_digits", dig, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_update", bus.update, 0);
        check("midrst_alarm", bus.alarm, 0);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        sbq.push_back('{dig: 24'h010205, cyc: cyc + 8, bsy: 7});
        wait_idle();

        check("queue_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
